eq_menu_ctrl: RTL and testbench
===============================

EQ_MENU_CTRL -- requirements
Module: eq_menu_ctrl

Interface
REQ-001 The block SHALL have parameter GAIN_FLAT, default 4'd8, giving the flat per-band gain code loaded at reset and on clear.
REQ-002 The block SHALL have parameter GAIN_MAX, default 4'd15, giving the upper saturation limit of a band gain code.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock (audio bit clock domain); all logic is clocked on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_select, input, 1 bit: debounced one-cycle key pulse.
REQ-006 The block SHALL have port i_back, input, 1 bit: debounced one-cycle key pulse.
REQ-007 The block SHALL have port i_up, input, 1 bit: debounced one-cycle key pulse.
REQ-008 The block SHALL have port i_down, input, 1 bit: debounced one-cycle key pulse.
REQ-009 The block SHALL have port o_menu_state, output, 3 bits: current menu state code, consumed by the seven-segment decoder.
REQ-010 The block SHALL have port o_cursor, output, 2 bits: root-menu item index.
REQ-011 The block SHALL have port o_band, output, 3 bits: selected EQ band, 0..7.
REQ-012 The block SHALL have port o_gain, output, 32 bits: eight 4-bit gain codes, band b at bits [4b+3:4b].
REQ-013 The block SHALL have port o_offset, output, 3 bits: global output offset, 0..7.
REQ-014 The block SHALL have port o_commit, output, 1 bit: one-cycle pulse whenever o_gain or o_offset takes a committed new value.

Function
REQ-015 The state codes SHALL be: ROOT=0, BAND_SEL=1, GAIN_EDIT=2, OFFSET_EDIT=3, CLEAR_CONFIRM=4; codes 5..7 SHALL go to ROOT on the next edge.
REQ-016 All outputs SHALL be registered; a pulse sampled at edge N SHALL be reflected on the outputs immediately after edge N (one-edge latency).
REQ-017 When several pulses are high in one cycle, only the highest-priority pulse SHALL act, in the order back > select > up > down; the others SHALL be discarded.
REQ-018 In ROOT, up SHALL move o_cursor 0→1→2→0 and down SHALL move it 0→2→1→0; select SHALL go to BAND_SEL (cursor 0), OFFSET_EDIT (cursor 1) or CLEAR_CONFIRM (cursor 2); back SHALL do nothing.
REQ-019 In BAND_SEL, up and down SHALL change o_band by +1 and -1 with wrap-around (7→0, 0→7); back SHALL go to ROOT.
REQ-020 In BAND_SEL, select SHALL copy the current band's gain into a save register and go to GAIN_EDIT.
REQ-021 In GAIN_EDIT, up SHALL increment the selected nibble and saturate at GAIN_MAX; down SHALL decrement it and saturate at 0; o_gain SHALL update live with no commit pulse.
REQ-022 In GAIN_EDIT, select SHALL keep the nibble, pulse o_commit and go to BAND_SEL.
REQ-023 In GAIN_EDIT, back SHALL restore the nibble from the save register, give no pulse and go to BAND_SEL.
REQ-024 In OFFSET_EDIT, up and down SHALL change o_offset by ±1 and saturate at 7 and 0; each change SHALL pulse o_commit; select or back SHALL go to ROOT.
REQ-025 In CLEAR_CONFIRM, select SHALL load every nibble with GAIN_FLAT, pulse o_commit and go to ROOT; back SHALL go to ROOT with gains unchanged; up and down SHALL be ignored.
REQ-026 A saturated up or down (no value change) SHALL NOT pulse o_commit.
REQ-027 o_commit SHALL be high for exactly one cycle per committing event.
REQ-028 Non-selected gain nibbles SHALL never change except through a clear.
REQ-029 o_band SHALL be retained across menu exits and re-entries.

Reset
REQ-030 When i_rst=0 at a rising edge, the outputs SHALL become: o_menu_state=0, o_cursor=0, o_band=0, o_gain=32'h8888_8888 (GAIN_FLAT in every nibble), o_offset=0, o_commit=0, and the save register SHALL be 0.
REQ-031 Reset SHALL override all key pulses in the same cycle.
REQ-032 Reset asserted during GAIN_EDIT SHALL discard the edit and load flat gains.

Verification
REQ-033 Scenario 1: reset, then select, select, up×3, select -> o_gain[3:0]=4'hB, o_menu_state=1, o_commit high for 1 cycle.
REQ-034 Scenario 2: in BAND_SEL with band 0, down -> o_band=7; then select, down×10 -> nibble 7 reads 0 (saturated), and a further down keeps o_commit=0.
REQ-035 Scenario 3: in GAIN_EDIT on band 2, up×4, then back -> nibble 2 returns to 8, state=1, no o_commit pulse.
REQ-036 Scenario 4: i_up and i_back high in the same cycle while in GAIN_EDIT -> back acts only, nibble restored, state=1.
REQ-037 Scenario 5: set nibbles to arbitrary values, then ROOT, up×2, select, select -> o_gain=32'h8888_8888, state=0, one o_commit pulse.
REQ-038 Scenario 6: set offset to 7, then up -> o_offset stays 7 with no commit; then i_rst=0 in the same cycle as a select pulse -> all reset values, select ignored.

Source files
------------

// File: rtl/eq_menu_ctrl.sv
// Front-panel menu controller for the eight-band graphic EQ: walks the menu on
// debounced key pulses and owns the per-band gain codes and the output offset.
module eq_menu_ctrl #(
    parameter logic [3:0] GAIN_FLAT = 4'd8,
    parameter logic [3:0] GAIN_MAX  = 4'd15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_select,
    input  logic        i_back,
    input  logic        i_up,
    input  logic        i_down,
    output logic [2:0]  o_menu_state,
    output logic [1:0]  o_cursor,
    output logic [2:0]  o_band,
    output logic [31:0] o_gain,
    output logic [2:0]  o_offset,
    output logic        o_commit
);

    typedef enum logic [2:0] {
        ST_ROOT          = 3'd0,
        ST_BAND_SEL      = 3'd1,
        ST_GAIN_EDIT     = 3'd2,
        ST_OFFSET_EDIT   = 3'd3,
        ST_CLEAR_CONFIRM = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cursor;
    logic [2:0]  r_band;
    logic [31:0] r_gain;
    logic [2:0]  r_offset;
    logic        r_commit;
    logic [3:0]  r_save;

    logic        w_back;
    logic        w_sel;
    logic        w_up;
    logic        w_down;
    logic [4:0]  w_idx;
    logic [3:0]  w_nib;

    function automatic logic [31:0] flat_gains(input logic [3:0] g);
        return {8{g}};
    endfunction

    // Key arbitration: back > select > up > down, losers are dropped.
    always_comb begin
        w_back = i_back;
        w_sel  = i_select & ~i_back;
        w_up   = i_up & ~i_back & ~i_select;
        w_down = i_down & ~i_back & ~i_select & ~i_up;
    end

    assign w_idx = {r_band, 2'b00};
    assign w_nib = r_gain[w_idx +: 4];

    // Menu state machine together with the gain/offset storage it edits.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= ST_ROOT;
            r_cursor <= 2'd0;
            r_band   <= 3'd0;
            r_gain   <= flat_gains(GAIN_FLAT);
            r_offset <= 3'd0;
            r_commit <= 1'b0;
            r_save   <= 4'd0;
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                ST_ROOT: begin
                    if (w_sel) begin
                        case (r_cursor)
                            2'd0:    r_state <= ST_BAND_SEL;
                            2'd1:    r_state <= ST_OFFSET_EDIT;
                            2'd2:    r_state <= ST_CLEAR_CONFIRM;
                            default: r_cursor <= 2'd0;
                        endcase
                    end else if (w_up) begin
                        r_cursor <= (r_cursor >= 2'd2) ? 2'd0 : r_cursor + 2'd1;
                    end else if (w_down) begin
                        r_cursor <= (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
                    end
                end
                ST_BAND_SEL: begin
                    if (w_back) begin
                        r_state <= ST_ROOT;
                    end else if (w_sel) begin
                        r_save  <= w_nib;
                        r_state <= ST_GAIN_EDIT;
                    end else if (w_up) begin
                        r_band <= r_band + 3'd1;
                    end else if (w_down) begin
                        r_band <= r_band - 3'd1;
                    end
                end
                ST_GAIN_EDIT: begin
                    // Gain edits are live; back rolls the nibble back to its entry value.
                    if (w_back) begin
                        r_gain[w_idx +: 4] <= r_save;
                        r_state            <= ST_BAND_SEL;
                    end else if (w_sel) begin
                        r_commit <= 1'b1;
                        r_state  <= ST_BAND_SEL;
                    end else if (w_up) begin
                        if (w_nib < GAIN_MAX) r_gain[w_idx +: 4] <= w_nib + 4'd1;
                    end else if (w_down) begin
                        if (w_nib != 4'd0) r_gain[w_idx +: 4] <= w_nib - 4'd1;
                    end
                end
                ST_OFFSET_EDIT: begin
                    if (w_back || w_sel) begin
                        r_state <= ST_ROOT;
                    end else if (w_up) begin
                        if (r_offset != 3'd7) begin
                            r_offset <= r_offset + 3'd1;
                            r_commit <= 1'b1;
                        end
                    end else if (w_down) begin
                        if (r_offset != 3'd0) begin
                            r_offset <= r_offset - 3'd1;
                            r_commit <= 1'b1;
                        end
                    end
                end
                ST_CLEAR_CONFIRM: begin
                    if (w_back) begin
                        r_state <= ST_ROOT;
                    end else if (w_sel) begin
                        r_gain   <= flat_gains(GAIN_FLAT);
                        r_commit <= 1'b1;
                        r_state  <= ST_ROOT;
                    end
                end
                default: r_state <= ST_ROOT;
            endcase
        end
    end

    assign o_menu_state = r_state;
    assign o_cursor     = r_cursor;
    assign o_band       = r_band;
    assign o_gain       = r_gain;
    assign o_offset     = r_offset;
    assign o_commit     = r_commit;

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Scoreboard bench for eq_menu_ctrl: directed key vectors with hand-computed
// expected outputs queued per cycle and checked by an independent monitor.
module tb_eq_menu_ctrl;

    logic        clk;
    logic        i_rst;
    logic        i_select, i_back, i_up, i_down;
    logic [2:0]  o_menu_state;
    logic [1:0]  o_cursor;
    logic [2:0]  o_band;
    logic [31:0] o_gain;
    logic [2:0]  o_offset;
    logic        o_commit;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  cur;
        logic [2:0]  band;
        logic [31:0] gain;
        logic [2:0]  off;
        logic        cm;
    } exp_t;

    exp_t exp_q[$];

    // keys: {select, back, up, down}
    localparam logic [3:0] K_N = 4'b0000;
    localparam logic [3:0] K_S = 4'b1000;
    localparam logic [3:0] K_B = 4'b0100;
    localparam logic [3:0] K_U = 4'b0010;
    localparam logic [3:0] K_D = 4'b0001;

    eq_menu_ctrl #(.GAIN_FLAT(4'd8), .GAIN_MAX(4'd15)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_select(i_select), .i_back(i_back),
        .i_up(i_up), .i_down(i_down), .o_menu_state(o_menu_state),
        .o_cursor(o_cursor), .o_band(o_band), .o_gain(o_gain),
        .o_offset(o_offset), .o_commit(o_commit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",  {29'd0, o_menu_state}, {29'd0, e.st});
                chk("cursor", {30'd0, o_cursor},     {30'd0, e.cur});
                chk("band",   {29'd0, o_band},       {29'd0, e.band});
                chk("gain",   o_gain,                e.gain);
                chk("offset", {29'd0, o_offset},     {29'd0, e.off});
                chk("commit", {31'd0, o_commit},     {31'd0, e.cm});
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] k, input logic [2:0] st,
                        input logic [1:0] cur, input logic [2:0] band,
                        input logic [31:0] gain, input logic [2:0] off, input logic cm);
        exp_t e;
        @(negedge clk);
        i_rst = rst;
        {i_select, i_back, i_up, i_down} = k;
        e.st = st; e.cur = cur; e.band = band; e.gain = gain; e.off = off; e.cm = cm;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [3:0] nib;
        int         wait_cycles;
        i_rst = 1'b0;
        {i_select, i_back, i_up, i_down} = 4'b0000;

        // Reset values
        step(1'b0, K_N, 3'd0, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);
        step(1'b0, K_N, 3'd0, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);

        // Scenario 1: edit band 0 up by three and commit
        step(1'b1, K_S, 3'd1, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd2, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd0, 32'h8888_8889, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd0, 32'h8888_888A, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd0, 32'h8888_888B, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd1, 2'd0, 3'd0, 32'h8888_888B, 3'd0, 1'b1);
        step(1'b1, K_N, 3'd1, 2'd0, 3'd0, 32'h8888_888B, 3'd0, 1'b0);

        // Scenario 2: band wrap 0->7, saturate nibble 7 at zero
        step(1'b1, K_D, 3'd1, 2'd0, 3'd7, 32'h8888_888B, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd2, 2'd0, 3'd7, 32'h8888_888B, 3'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            nib = (i <= 8) ? 4'(8 - i) : 4'd0;
            step(1'b1, K_D, 3'd2, 2'd0, 3'd7, {nib, 28'h888_888B}, 3'd0, 1'b0);
        end
        step(1'b1, K_D, 3'd2, 2'd0, 3'd7, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd1, 2'd0, 3'd7, 32'h0888_888B, 3'd0, 1'b1);

        // Scenario 3: band wrap 7->0, edit band 2 then abandon with back
        step(1'b1, K_U, 3'd1, 2'd0, 3'd0, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd1, 2'd0, 3'd1, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd1, 2'd0, 3'd2, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd2, 2'd0, 3'd2, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd2, 32'h0888_8A8B, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd2, 32'h0888_8B8B, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd2, 32'h0888_8C8B, 3'd0, 1'b0);
        step(1'b1, K_B, 3'd1, 2'd0, 3'd2, 32'h0888_888B, 3'd0, 1'b0);

        // Scenario 4: simultaneous keys resolved by priority
        step(1'b1, K_S,       3'd2, 2'd0, 3'd2, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_U,       3'd2, 2'd0, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        step(1'b1, K_U | K_B, 3'd1, 2'd0, 3'd2, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_S | K_U, 3'd2, 2'd0, 3'd2, 32'h0888_888B, 3'd0, 1'b0);
        step(1'b1, K_U | K_D, 3'd2, 2'd0, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        step(1'b1, K_S,       3'd1, 2'd0, 3'd2, 32'h0888_898B, 3'd0, 1'b1);
        step(1'b1, K_B,       3'd0, 2'd0, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        step(1'b1, K_B,       3'd0, 2'd0, 3'd2, 32'h0888_898B, 3'd0, 1'b0);

        // Offset edit: saturation at both ends, commit on every real change
        step(1'b1, K_U, 3'd0, 2'd1, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd3, 2'd1, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        step(1'b1, K_D, 3'd3, 2'd1, 3'd2, 32'h0888_898B, 3'd0, 1'b0);
        for (int i = 1; i <= 7; i++)
            step(1'b1, K_U, 3'd3, 2'd1, 3'd2, 32'h0888_898B, 3'(i), 1'b1);
        step(1'b1, K_U, 3'd3, 2'd1, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_S, 3'd0, 2'd1, 3'd2, 32'h0888_898B, 3'd7, 1'b0);

        // Band retained on re-entry; clear cancelled, then confirmed (scenario 5)
        step(1'b1, K_D, 3'd0, 2'd0, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_S, 3'd1, 2'd0, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_B, 3'd0, 2'd0, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_U, 3'd0, 2'd1, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_U, 3'd0, 2'd2, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_S, 3'd4, 2'd2, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_U, 3'd4, 2'd2, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_D, 3'd4, 2'd2, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_B, 3'd0, 2'd2, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_S, 3'd4, 2'd2, 3'd2, 32'h0888_898B, 3'd7, 1'b0);
        step(1'b1, K_S, 3'd0, 2'd2, 3'd2, 32'h8888_8888, 3'd7, 1'b1);
        step(1'b1, K_N, 3'd0, 2'd2, 3'd2, 32'h8888_8888, 3'd7, 1'b0);

        // Root cursor wrap in both directions
        step(1'b1, K_D, 3'd0, 2'd1, 3'd2, 32'h8888_8888, 3'd7, 1'b0);
        step(1'b1, K_D, 3'd0, 2'd0, 3'd2, 32'h8888_8888, 3'd7, 1'b0);
        step(1'b1, K_D, 3'd0, 2'd2, 3'd2, 32'h8888_8888, 3'd7, 1'b0);
        step(1'b1, K_U, 3'd0, 2'd0, 3'd2, 32'h8888_8888, 3'd7, 1'b0);
        step(1'b1, K_U, 3'd0, 2'd1, 3'd2, 32'h8888_8888, 3'd7, 1'b0);

        // Scenario 6: reset overrides a same-cycle select
        step(1'b0, K_S, 3'd0, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);

        // Reset during a gain edit discards the edit
        step(1'b1, K_S, 3'd1, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);
        step(1'b1, K_S, 3'd2, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);
        step(1'b1, K_U, 3'd2, 2'd0, 3'd0, 32'h8888_8889, 3'd0, 1'b0);
        step(1'b0, K_U, 3'd0, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);
        step(1'b1, K_N, 3'd0, 2'd0, 3'd0, 32'h8888_8888, 3'd0, 1'b0);

        @(negedge clk);
        {i_select, i_back, i_up, i_down} = 4'b0000;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
